// File: rtl/apb_controller.sv
// APB-side half of the AHB-to-APB bridge: sequences SETUP/ENABLE phases from the
// pipelined AHB transfer info and stalls the AHB master via Hreadyout.
module apb_controller #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NSLV   = 3
) (
  input  logic              Hclk,
  input  logic              Hreset,
  input  logic              Valid,
  input  logic              Hwrite,
  input  logic              Hwrite_reg,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic [ADDR_W-1:0] Haddr1,
  input  logic [ADDR_W-1:0] Haddr2,
  input  logic [DATA_W-1:0] Hwdata,
  input  logic [DATA_W-1:0] Hdata1,
  input  logic [DATA_W-1:0] Prdata,
  output logic [NSLV-1:0]   Pselx,
  output logic              Penable,
  output logic              Pwrite,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  output logic              Hreadyout,
  output logic [DATA_W-1:0] Hrdata
);

  // Peripheral windows are 64 MB each starting at 0x8000_0000.
  localparam int unsigned REGION_W    = 6;
  localparam int unsigned REGION_BASE = 32;

  typedef enum logic [2:0] {
    IDLE, WWAIT, READ, RENABLE, WRITE, WRITEP, WENABLE, WENABLEP
  } state_t;

  state_t              state, state_n;
  logic [NSLV-1:0]     pselx_n;
  logic                penable_n;
  logic                pwrite_n;
  logic [ADDR_W-1:0]   paddr_n;
  logic [DATA_W-1:0]   pwdata_n;
  logic                hready_n;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;

  function automatic logic [NSLV-1:0] dec(input logic [REGION_W-1:0] region);
    logic [NSLV-1:0] sel;
    sel = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (region == REGION_W'(REGION_BASE + i)) sel[i] = 1'b1;
    end
    return sel;
  endfunction

  // State and registered outputs load together with next-state values.
  always_ff @(posedge Hclk or negedge Hreset) begin
    if (!Hreset) begin
      state     <= IDLE;
      Pselx     <= '0;
      Penable   <= 1'b0;
      Pwrite    <= 1'b0;
      Paddr     <= '0;
      Pwdata    <= '0;
      Hreadyout <= 1'b1;
    end else begin
      state     <= state_n;
      Pselx     <= pselx_n;
      Penable   <= penable_n;
      Pwrite    <= pwrite_n;
      Paddr     <= paddr_n;
      Pwdata    <= pwdata_n;
      Hreadyout <= hready_n;
    end
  end

  always_comb begin
    state_n   = state;
    pselx_n   = Pselx;
    penable_n = Penable;
    pwrite_n  = Pwrite;
    paddr_n   = Paddr;
    pwdata_n  = Pwdata;
    hready_n  = Hreadyout;
    // A write following a pipelined write takes the older address/data stage.
    wr_addr   = (state == WENABLEP) ? Haddr2 : Haddr1;
    wr_data   = (state == WENABLEP) ? Hdata1 : Hwdata;

    case (state)
      IDLE, RENABLE, WENABLE: begin
        if (Valid && Hwrite)       state_n = WWAIT;
        else if (Valid && !Hwrite) state_n = READ;
        else                       state_n = IDLE;
      end
      WWAIT:    state_n = Valid ? WRITEP : WRITE;
      READ:     state_n = RENABLE;
      WRITE:    state_n = Valid ? WENABLEP : WENABLE;
      WRITEP:   state_n = WENABLEP;
      WENABLEP: begin
        if (!Hwrite_reg) state_n = READ;
        else if (Valid)  state_n = WRITEP;
        else             state_n = WRITE;
      end
    endcase

    case (state_n)
      IDLE, WWAIT: begin
        pselx_n   = '0;
        penable_n = 1'b0;
        hready_n  = 1'b1;
      end
      READ: begin
        paddr_n   = Haddr;
        pwrite_n  = 1'b0;
        pselx_n   = dec(Haddr[ADDR_W-1 -: REGION_W]);
        penable_n = 1'b0;
        hready_n  = 1'b0;
      end
      WRITE, WRITEP: begin
        paddr_n   = wr_addr;
        pwdata_n  = wr_data;
        pwrite_n  = 1'b1;
        pselx_n   = dec(wr_addr[ADDR_W-1 -: REGION_W]);
        penable_n = 1'b0;
        hready_n  = (state_n == WRITE);
      end
      RENABLE, WENABLE: begin
        penable_n = 1'b1;
        hready_n  = 1'b1;
      end
      WENABLEP: begin
        penable_n = 1'b1;
        hready_n  = 1'b0;
      end
    endcase
  end

  assign Hrdata = (state == RENABLE) ? Prdata : '0;

endmodule

// File: doc/apb_controller.md
Name: apb_controller

Overview:
APB-side half of the AHB-to-APB bridge. Consumes the pipelined transfer information produced by the AHB slave interface (Valid, Hwrite, Hwrite_reg, address/data pipeline registers). Drives a single-master APB bus with SETUP/ENABLE phasing, returns read data, and stalls the AHB master through Hreadyout while APB phases complete.

Parameters:
ADDR_W, 32, AHB/APB address width
DATA_W, 32, AHB/APB data width
NSLV, 3, number of APB peripherals (width of Pselx)

Ports:
Hclk  input  1  system clock; all state updates on rising edge
Hreset  input  1  asynchronous active-low reset
Valid  input  1  legal AHB transfer in address phase (from AHB slave interface)
Hwrite  input  1  direction of the current address-phase transfer
Hwrite_reg  input  1  Hwrite delayed by one Hclk
Haddr  input  ADDR_W  current AHB address
Haddr1  input  ADDR_W  Haddr delayed by 1 cycle
Haddr2  input  ADDR_W  Haddr delayed by 2 cycles
Hwdata  input  DATA_W  current AHB write data
Hdata1  input  DATA_W  Hwdata delayed by 1 cycle
Prdata  input  DATA_W  APB read data
Pselx  output  NSLV  one-hot APB peripheral select
Penable  output  1  APB enable phase
Pwrite  output  1  APB direction (1 = write)
Paddr  output  ADDR_W  APB address
Pwdata  output  DATA_W  APB write data
Hreadyout  output  1  AHB ready back to master
Hrdata  output  DATA_W  AHB read data

Behaviour:
- Reset (Hreset=0, asynchronous): state=IDLE; Pselx=0; Penable=0; Pwrite=0; Paddr=0; Pwdata=0; Hreadyout=1. Reset mid-transfer aborts immediately; no completion.
- States: IDLE, WWAIT, READ, RENABLE, WRITE, WRITEP, WENABLE, WENABLEP.
- Transitions:
  - IDLE: Valid&Hwrite -> WWAIT; Valid&!Hwrite -> READ; else IDLE.
  - WWAIT: Valid -> WRITEP; else WRITE.
  - READ -> RENABLE.
  - RENABLE and WENABLE: Valid&Hwrite -> WWAIT; Valid&!Hwrite -> READ; else IDLE.
  - WRITE: Valid -> WENABLEP; else WENABLE.
  - WRITEP -> WENABLEP.
  - WENABLEP: !Hwrite_reg -> READ; Hwrite_reg&Valid -> WRITEP; Hwrite_reg&!Valid -> WRITE.
- All outputs except Hrdata are registered. They load on the same edge the state loads, taking the values defined for the next state.
- Per-state values:
  - IDLE / WWAIT: Pselx=0, Penable=0, Hreadyout=1; Paddr/Pwdata/Pwrite hold.
  - READ: Paddr=Haddr, Pwrite=0, Pselx=dec(Haddr), Penable=0, Hreadyout=0.
  - WRITE / WRITEP entered from WWAIT: Paddr=Haddr1, Pwdata=Hwdata.
  - WRITE / WRITEP entered from WENABLEP: Paddr=Haddr2, Pwdata=Hdata1.
  - In both WRITE and WRITEP: Pwrite=1, Pselx=dec(Paddr source), Penable=0. Hreadyout=1 in WRITE, 0 in WRITEP.
  - RENABLE / WENABLE / WENABLEP: Penable=1; Pselx, Paddr, Pwdata, Pwrite hold. Hreadyout=1 except WENABLEP=0.
- dec(a): bit0 for 0x8000_0000–0x83FF_FFFF, bit1 for 0x8400_0000–0x87FF_FFFF, bit2 for 0x8800_0000–0x8BFF_FFFF, 0 otherwise. An unmapped address still runs the FSM, with Pselx=0.
- Hrdata = Prdata combinationally whenever state=RENABLE, else 0.
- Every APB transfer is exactly one SETUP cycle followed by one ENABLE cycle. Pselx, Paddr, Pwdata and Pwrite are stable across both; Penable is never 1 in the first cycle Pselx rises.
- Read latency: Valid sampled in IDLE -> SETUP next cycle -> ENABLE cycle, Hrdata valid with Hreadyout=1.
- Back-to-back writes go through WRITEP/WENABLEP with Hreadyout low so the master holds its pipeline.

Test Plan:
- Reset: drive Hreset=0 during WENABLE -> same cycle Pselx=000, Penable=0, Hreadyout=1; after release, state=IDLE.
- Single read at Haddr=0x8400_0010, Prdata=0xDEAD_BEEF -> cycle1 Pselx=010, Paddr=0x8400_0010, Pwrite=0, Penable=0, Hreadyout=0; cycle2 Penable=1, Hrdata=0xDEAD_BEEF, Hreadyout=1; cycle3 Pselx=000.
- Single write at 0x8000_0004 with data 0x1234_5678 -> WWAIT, then Pselx=001, Paddr=0x8000_0004, Pwdata=0x1234_5678, Pwrite=1; then Penable=1; then IDLE.
- Back-to-back writes to 0x8800_0000 and 0x8800_0004 (data 0xA, 0xB) -> two SETUP/ENABLE pairs in order with Pselx=100. Hreadyout=0 during WRITEP/WENABLEP; the second transfer uses Paddr=0x8800_0004, Pwdata=0xB.
- Write then read (0x8000_0000 write, 0x8000_0008 read) -> WENABLEP -> READ with Pwrite=0, Paddr=0x8000_0008.
- Unmapped address 0x9000_0000 forced with Valid=1, read -> FSM runs READ->RENABLE with Pselx=000, Penable=1 in the second cycle.
